// File: rtl/st7920_fb_serial_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : st7920_pkg
// Purpose  : ST7920 command set, serial frame builder and driver FSM states.
// Revision : 1.0  initial release
// ============================================================================
package st7920_pkg;

  localparam logic [7:0] FUNC_BASIC = 8'h30;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY      = 8'h06;
  localparam logic [7:0] FUNC_EXT   = 8'h34;
  localparam logic [7:0] GFX_ON     = 8'h36;
  localparam logic [7:0] SET_ADDR   = 8'h80;
  localparam logic [4:0] SYNC       = 5'b11111;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_BOOT    = 3'd1,
    ST_SET_Y   = 3'd2,
    ST_SET_X   = 3'd3,
    ST_DATA    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Sync header, RW=0, RS, 0, then each nibble padded with four zeros.
  function automatic logic [23:0] build_frame(input logic rs, input logic [7:0] b);
    return {SYNC, 1'b0, rs, 1'b0, b[7:4], 4'b0000, b[3:0], 4'b0000};
  endfunction

  function automatic logic [7:0] boot_cmd(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = FUNC_BASIC;
      3'd1:    c = DISP_ON;
      3'd2:    c = CLEAR;
      3'd3:    c = ENTRY;
      3'd4:    c = FUNC_EXT;
      default: c = GFX_ON;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/st7920_fb_serial_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : st7920_fb_serial_driver_if
// Purpose  : ST7920 serial pin bundle (SCLK on E, SID on R/W).
// Revision : 1.0  initial release
// ============================================================================
interface st7920_fb_serial_driver_if;
  logic lcd_clk;
  logic lcd_data;

  modport master (output lcd_clk, output lcd_data);
  modport slave  (input  lcd_clk, input  lcd_data);
endinterface
`default_nettype wire

// File: rtl/st7920_fb_serial_driver_tx.sv
`default_nettype none
// ============================================================================
// Module   : st7920_serial_tx
// Purpose  : Shifts one 24-bit ST7920 frame MSB first; SID changes with SCLK fall.
// Revision : 1.0  initial release
// ============================================================================
module st7920_serial_tx #(
  parameter int CLK_HALF = 128
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic [23:0] frame,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sid
);

  localparam logic [7:0] C_DIV_LAST = 8'(CLK_HALF - 1);
  localparam logic [4:0] C_BIT_LAST = 5'd23;

  logic        r_busy;
  logic        r_phase;
  logic [7:0]  r_div;
  logic [4:0]  r_bit;
  logic [23:0] r_shift;
  logic        w_half_end;

  assign w_half_end = (r_div == C_DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_phase <= 1'b0;
      r_div   <= 8'd0;
      r_bit   <= 5'd0;
      r_shift <= 24'd0;
    end else if (!r_busy) begin
      if (start) begin
        r_busy  <= 1'b1;
        r_phase <= 1'b0;
        r_div   <= 8'd0;
        r_bit   <= 5'd0;
        r_shift <= frame;
      end
    end else if (w_half_end) begin
      r_div   <= 8'd0;
      r_phase <= ~r_phase;
      // Shifting a zero in on every fall leaves SID low once the word is out.
      if (r_phase) begin
        r_shift <= {r_shift[22:0], 1'b0};
        if (r_bit == C_BIT_LAST) begin
          r_busy <= 1'b0;
        end else begin
          r_bit <= r_bit + 5'd1;
        end
      end
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  assign busy = r_busy;
  assign done = r_busy && r_phase && w_half_end && (r_bit == C_BIT_LAST);
  assign sclk = r_phase;
  assign sid  = r_shift[23];

endmodule
`default_nettype wire

// File: rtl/st7920_fb_serial_driver.sv
`default_nettype none
// ============================================================================
// Module   : st7920_fb_serial_driver
// Purpose  : Boots an ST7920 into graphics mode, then streams a 128x64 frame forever.
// Revision : 1.0  initial release
// ============================================================================
module st7920_fb_serial_driver
  import st7920_pkg::*;
#(
  parameter int CLK_HALF      = 128,
  parameter int CMD_GAP       = 2048,
  parameter int CLEAR_GAP     = 65536,
  parameter int POWERUP_DELAY = 1048576,
  parameter int BOOT_INSTRS   = 6
) (
  input  wire logic                sys_clk,
  input  wire logic                sys_rst_n_ms,
  input  wire logic [7:0]          memory [0:1023],
  st7920_fb_serial_driver_if.master lcd,
  output logic [5:0]               led
);

  localparam int MAX_WAIT = (POWERUP_DELAY > CLEAR_GAP)
                          ? ((POWERUP_DELAY > CMD_GAP) ? POWERUP_DELAY : CMD_GAP)
                          : ((CLEAR_GAP > CMD_GAP) ? CLEAR_GAP : CMD_GAP);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  // Gap compares are two short: the tx-done cycle and the next load cycle are idle too.
  localparam logic [CNT_W-1:0] C_POWERUP_LAST = CNT_W'(POWERUP_DELAY - 1);
  localparam logic [CNT_W-1:0] C_CMD_LAST     = CNT_W'(CMD_GAP - 2);
  localparam logic [CNT_W-1:0] C_CLEAR_LAST   = CNT_W'(CLEAR_GAP - 2);
  localparam logic [2:0]       C_BOOT_LAST    = 3'(BOOT_INSTRS - 1);

  state_t           r_state, w_state_nxt;
  state_t           r_ret, w_ret_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_boot_idx, w_boot_idx_nxt;
  logic [4:0]       r_y, w_y_nxt;
  logic [4:0]       r_byte, w_byte_nxt;
  logic [4:0]       r_frame_cnt, w_frame_cnt_nxt;
  logic             r_active, w_active_nxt;
  logic             r_issued, w_issued_nxt;
  logic             r_gap_clear, w_gap_clear_nxt;

  logic             w_tx_start;
  logic [23:0]      w_tx_frame;
  logic             w_tx_busy;
  logic             w_tx_done;
  logic             w_sclk;
  logic             w_sid;
  logic             w_xfer;
  logic [CNT_W-1:0] w_gap_last;
  logic [9:0]       w_addr;

  // Bytes 0..15 come from row y (upper half), bytes 16..31 from row y+32.
  assign w_addr     = {r_byte[4], r_y, r_byte[3:0]};
  assign w_gap_last = r_gap_clear ? C_CLEAR_LAST : C_CMD_LAST;

  always_ff @(posedge sys_clk or negedge sys_rst_n_ms) begin
    if (!sys_rst_n_ms) begin
      r_state     <= ST_POWERUP;
      r_ret       <= ST_POWERUP;
      r_cnt       <= '0;
      r_boot_idx  <= 3'd0;
      r_y         <= 5'd0;
      r_byte      <= 5'd0;
      r_frame_cnt <= 5'd0;
      r_active    <= 1'b0;
      r_issued    <= 1'b0;
      r_gap_clear <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret       <= w_ret_nxt;
      r_cnt       <= w_cnt_nxt;
      r_boot_idx  <= w_boot_idx_nxt;
      r_y         <= w_y_nxt;
      r_byte      <= w_byte_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_active    <= w_active_nxt;
      r_issued    <= w_issued_nxt;
      r_gap_clear <= w_gap_clear_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ret_nxt       = r_ret;
    w_cnt_nxt       = r_cnt;
    w_boot_idx_nxt  = r_boot_idx;
    w_y_nxt         = r_y;
    w_byte_nxt      = r_byte;
    w_frame_cnt_nxt = r_frame_cnt;
    w_active_nxt    = r_active;
    w_issued_nxt    = r_issued;
    w_gap_clear_nxt = r_gap_clear;
    w_tx_start      = 1'b0;
    w_tx_frame      = 24'd0;
    w_xfer          = 1'b0;

    case (r_state)
      ST_POWERUP: begin
        if (r_cnt == C_POWERUP_LAST) begin
          w_state_nxt = ST_BOOT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_BOOT: begin
        w_xfer     = 1'b1;
        w_tx_frame = build_frame(1'b0, boot_cmd(r_boot_idx));
      end
      ST_SET_Y: begin
        w_xfer     = 1'b1;
        w_tx_frame = build_frame(1'b0, SET_ADDR | {3'b000, r_y});
      end
      ST_SET_X: begin
        w_xfer     = 1'b1;
        w_tx_frame = build_frame(1'b0, SET_ADDR);
      end
      ST_DATA: begin
        w_xfer     = 1'b1;
        w_tx_frame = build_frame(1'b1, memory[w_addr]);
      end
      ST_GAP: begin
        if (r_cnt == w_gap_last) begin
          w_state_nxt = r_ret;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_POWERUP;
    endcase

    if (w_xfer) begin
      w_tx_start = !r_issued && !w_tx_busy;
      if (w_tx_start) begin
        w_issued_nxt = 1'b1;
        if (r_state == ST_SET_Y) begin
          w_active_nxt = 1'b1;
        end
      end
      if (w_tx_done) begin
        w_issued_nxt    = 1'b0;
        w_state_nxt     = ST_GAP;
        w_cnt_nxt       = '0;
        w_gap_clear_nxt = 1'b0;
        case (r_state)
          ST_BOOT: begin
            w_gap_clear_nxt = (boot_cmd(r_boot_idx) == CLEAR);
            if (r_boot_idx == C_BOOT_LAST) begin
              w_ret_nxt      = ST_SET_Y;
              w_boot_idx_nxt = 3'd0;
            end else begin
              w_ret_nxt      = ST_BOOT;
              w_boot_idx_nxt = r_boot_idx + 3'd1;
            end
          end
          ST_SET_Y: w_ret_nxt = ST_SET_X;
          ST_SET_X: begin
            w_ret_nxt  = ST_DATA;
            w_byte_nxt = 5'd0;
          end
          default: begin
            if (r_byte == 5'd31) begin
              w_ret_nxt = ST_SET_Y;
              w_y_nxt   = r_y + 5'd1;
              if (r_y == 5'd31) begin
                w_frame_cnt_nxt = r_frame_cnt + 5'd1;
              end
            end else begin
              w_ret_nxt  = ST_DATA;
              w_byte_nxt = r_byte + 5'd1;
            end
          end
        endcase
      end
    end
  end

  st7920_serial_tx #(
    .CLK_HALF (CLK_HALF)
  ) u_tx (
    .clk   (sys_clk),
    .rst_n (sys_rst_n_ms),
    .start (w_tx_start),
    .frame (w_tx_frame),
    .busy  (w_tx_busy),
    .done  (w_tx_done),
    .sclk  (w_sclk),
    .sid   (w_sid)
  );

  assign lcd.lcd_clk  = w_sclk;
  assign lcd.lcd_data = w_sid;
  assign led          = ~{r_active, r_frame_cnt};

endmodule
`default_nettype wire

// File: tb/tb_st7920_fb_serial_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_st7920_fb_serial_driver
// Purpose  : Scoreboard bench decoding SID on SCLK rises against queued frames.
// Revision : 1.0  initial release
// ============================================================================
module tb_st7920_fb_serial_driver;

  localparam int CLK_HALF      = 1;
  localparam int CMD_GAP       = 4;
  localparam int CLEAR_GAP     = 8;
  localparam int POWERUP_DELAY = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n_ms = 1'b0;
  logic [7:0] memory [0:1023];
  logic [5:0] led;

  st7920_fb_serial_driver_if lcd_bus ();

  st7920_fb_serial_driver #(
    .CLK_HALF      (CLK_HALF),
    .CMD_GAP       (CMD_GAP),
    .CLEAR_GAP     (CLEAR_GAP),
    .POWERUP_DELAY (POWERUP_DELAY),
    .BOOT_INSTRS   (6)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n_ms (sys_rst_n_ms),
    .memory       (memory),
    .lcd          (lcd_bus),
    .led          (led)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [23:0] frm;
    int          gap;
    logic [5:0]  led;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_seen = 0;

  function automatic logic [23:0] mk(input logic rs, input logic [7:0] b);
    mk = {5'b11111, 1'b0, rs, 1'b0, b[7:4], 4'h0, b[3:0], 4'h0};
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    if (i == 0)   return 8'hA5;
    if (i == 512) return 8'h3C;
    if (i == 80)  return 8'h5A;
    return 8'(i * 37 + 11);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [23:0] f, input int g, input logic [5:0] l);
    exp_t e;
    e.frm = f;
    e.gap = g;
    e.led = l;
    exp_q.push_back(e);
  endtask

  task automatic push_boot();
    push(24'hF83000, CMD_GAP,   6'b111111);
    push(24'hF800C0, CMD_GAP,   6'b111111);
    push(24'hF80010, CLEAR_GAP, 6'b111111);
    push(24'hF80060, CMD_GAP,   6'b111111);
    push(24'hF83040, CMD_GAP,   6'b111111);
    push(24'hF83060, CMD_GAP,   6'b111111);
  endtask

  // Monitor: decode SID on SCLK rises, time each word and the idle gap after it.
  int          cyc = 0;
  int          nb = 0;
  logic [23:0] sh = 24'd0;
  logic        prev = 1'b0;
  logic        in_gap = 1'b0;
  logic        loaded = 1'b0;
  int          gap_cnt = 0;
  int          pend_gap = 0;
  int          load_t = 0;
  int          t_first = 0;

  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (!sys_rst_n_ms) begin
      nb     = 0;
      in_gap = 1'b0;
      loaded = 1'b0;
      prev   = 1'b0;
    end else begin
      if (in_gap && !lcd_bus.lcd_clk) begin
        if (lcd_bus.lcd_data) begin
          check("gap_len", gap_cnt, pend_gap);
          in_gap = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (!in_gap && nb == 0 && !loaded && lcd_bus.lcd_data && !lcd_bus.lcd_clk) begin
        loaded = 1'b1;
        load_t = cyc;
      end
      if (lcd_bus.lcd_clk && !prev) begin
        if (nb == 0) begin
          t_first = cyc;
          if (loaded) check("low_half", cyc - load_t, CLK_HALF);
        end
        sh = {sh[22:0], lcd_bus.lcd_data};
        nb++;
        if (nb == 24) begin
          check("xfer_len", cyc - t_first, 46 * CLK_HALF);
          n_seen++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame", sh, e.frm);
            check("led", led, e.led);
            pend_gap = e.gap;
            in_gap   = 1'b1;
            gap_cnt  = 0;
          end
          nb     = 0;
          loaded = 1'b0;
        end
      end
      prev = lcd_bus.lcd_clk;
    end
  end

  initial begin
    int   first_rise;
    logic ok;

    for (int i = 0; i < 1024; i++) memory[i] = 8'(i * 37 + 11);
    memory[0]   = 8'hA5;
    memory[512] = 8'h3C;

    repeat (3) @(negedge sys_clk);
    check("rst_clk",  lcd_bus.lcd_clk, 1'b0);
    check("rst_data", lcd_bus.lcd_data, 1'b0);
    check("rst_led",  led, 6'b111111);

    push_boot();
    for (int y = 0; y < 32; y++) begin
      if (y == 31) push(24'hF890F0, CMD_GAP, 6'b011111);
      else         push(mk(1'b0, 8'h80 | 8'(y)), CMD_GAP, 6'b011111);
      push(24'hF88000, CMD_GAP, 6'b011111);
      for (int b = 0; b < 32; b++) begin
        if (y == 0 && b == 0)       push(24'hFAA050, CMD_GAP, 6'b011111);
        else if (y == 0 && b == 16) push(24'hFA30C0, CMD_GAP, 6'b011111);
        else push(mk(1'b1, exp_byte(((b >= 16) ? (y + 32) : y) * 16 + (b % 16))),
                  CMD_GAP, 6'b011111);
      end
    end
    push(24'hF88000, CMD_GAP, 6'b011110);
    push(24'hF88000, CMD_GAP, 6'b011110);

    sys_rst_n_ms = 1'b1;
    first_rise = 0;
    for (int k = 1; k <= 200 && first_rise == 0; k++) begin
      @(negedge sys_clk);
      if (k <= POWERUP_DELAY)
        check("powerup_idle", {lcd_bus.lcd_clk, lcd_bus.lcd_data, led}, {2'b00, 6'b111111});
      if (lcd_bus.lcd_clk) first_rise = k;
    end
    check("first_rise_seen", first_rise != 0, 1'b1);
    check("first_rise_late", first_rise > POWERUP_DELAY, 1'b1);

    // Row 5 is loaded long after row 1 begins, so this change must show up.
    for (int k = 0; k < 5000 && n_seen < 41; k++) @(negedge sys_clk);
    check("reach_row1", n_seen >= 41, 1'b1);
    memory[80] = 8'h5A;

    for (int k = 0; k < 70000 && exp_q.size() != 0; k++) @(negedge sys_clk);
    check("drain_frame", exp_q.size(), 0);

    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge sys_clk);
      if (lcd_bus.lcd_clk) ok = 1'b1;
    end
    check("mid_high_seen", ok, 1'b1);
    #2;
    sys_rst_n_ms = 1'b0;
    #1;
    check("abort_clk",  lcd_bus.lcd_clk, 1'b0);
    check("abort_data", lcd_bus.lcd_data, 1'b0);
    check("abort_led",  led, 6'b111111);

    exp_q.delete();
    push_boot();
    push(24'hF88000, CMD_GAP, 6'b011111);
    repeat (3) @(negedge sys_clk);
    sys_rst_n_ms = 1'b1;
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge sys_clk);
    check("drain_reboot", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
